// File: rtl/operand_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_defs : shared definitions for the 20-bit pipeline ID stage.
//   Default widths, opcode encodings, instruction field positions and the
//   decode table that says which register fields an opcode reads or writes.
// ---------------------------------------------------------------------------
package pipe_defs;

   localparam int DEF_DATA_W = 20;
   localparam int DEF_PC_W   = 8;
   localparam int DEF_CNT_W  = 16;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LD   = 4'd6;
   localparam logic [3:0] OP_ST   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;

   // MSB of each 4-bit field; the immediate is the low byte
   localparam int OP_MSB  = 19;
   localparam int RD_MSB  = 15;
   localparam int RS1_MSB = 11;
   localparam int RS2_MSB = 7;
   localparam int IMM_MSB = 7;

   typedef struct packed {
      logic uses_rs1;
      logic uses_src2;   // second read port carries rs2, or rd for ST/BEQ
      logic writes_rd;
   } dec_t;

   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            d.uses_rs1  = 1'b1;
            d.uses_src2 = 1'b1;
            d.writes_rd = 1'b1;
         end
         OP_ADDI, OP_LD: begin
            d.uses_rs1  = 1'b1;
            d.writes_rd = 1'b1;
         end
         OP_ST, OP_BEQ: begin
            d.uses_rs1  = 1'b1;
            d.uses_src2 = 1'b1;
         end
         default: d = '0;   // NOP and reserved opcodes 9-15
      endcase
      return d;
   endfunction

endpackage

// File: rtl/operand_fetch_stage_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard : 16-entry pending-write table for the ID stage.
//   clock/reset_n        clock, async active-low reset
//   src1_*/src2_*/dst_*  register numbers of the instruction in ID + use flags
//   set_i/set_addr_i     issue of a register-writing instruction
//   clr_i/clr_addr_i     writeback commit (also forwards: not a hazard)
//   kill_i/kill_addr_i   flushed ID/EX entry that never reached EX
//   hazard_o             instruction in ID must wait
// ---------------------------------------------------------------------------
module hazard_scoreboard (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] src1_addr_i,
   input  logic       src1_use_i,
   input  logic [3:0] src2_addr_i,
   input  logic       src2_use_i,
   input  logic [3:0] dst_addr_i,
   input  logic       dst_use_i,
   input  logic       set_i,
   input  logic [3:0] set_addr_i,
   input  logic       clr_i,
   input  logic [3:0] clr_addr_i,
   input  logic       kill_i,
   input  logic [3:0] kill_addr_i,
   output logic       hazard_o
);

   logic [15:0] pend_q, pend_d;
   logic [15:0] clr_mask;
   logic [15:0] live;

   assign clr_mask = clr_i ? (16'h0001 << clr_addr_i) : 16'h0000;
   // A register written back this cycle is readable at the next rising edge
   // (register file writes on the falling edge), so it no longer blocks.
   assign live = pend_q & ~clr_mask;

   assign hazard_o = (src1_use_i & live[src1_addr_i]) |
                     (src2_use_i & live[src2_addr_i]) |
                     (dst_use_i  & live[dst_addr_i]);

   always_comb begin
      pend_d = pend_q & ~clr_mask;
      if (kill_i) pend_d[kill_addr_i] = 1'b0;
      // set applied last: same-cycle issue and writeback of one register leaves it pending
      if (set_i)  pend_d[set_addr_i]  = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pend_q <= '0;
      else          pend_q <= pend_d;
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage : decode / operand-fetch stage.
//   if_*       instruction from fetch with valid/ready handshake
//   flush      discards the instruction in ID and the un-consumed ID/EX entry
//   rf_*       register-file read addresses (combinational) and read data
//   wb_*       writeback commit, clears the matching pending bit
//   ex_*       ID/EX pipeline register with valid/ready handshake
//   stall_cnt  saturating count of cycles lost to RAW/WAW hazards
// ---------------------------------------------------------------------------
module operand_fetch_stage
   import pipe_defs::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W   = DEF_PC_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_valid,
   input  logic [DATA_W-1:0] if_instr,
   input  logic [PC_W-1:0]   if_pc,
   output logic              if_ready,
   input  logic              flush,
   output logic [3:0]        rf_raddr1,
   output logic [3:0]        rf_raddr2,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   input  logic              wb_we,
   input  logic [3:0]        wb_addr,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [3:0]        ex_op,
   output logic [3:0]        ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [PC_W-1:0]   ex_pc,
   output logic              ex_wen,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [3:0]        op, rd, rs1, rs2;
   logic [DATA_W-1:0] imm;
   dec_t              dec;
   logic              hazard, space, issue, kill;

   logic              ex_valid_q, ex_valid_d;
   logic [3:0]        ex_op_q, ex_op_d, ex_rd_q, ex_rd_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
   logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
   logic              ex_wen_q, ex_wen_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   // ---- decode ----
   assign op  = if_instr[OP_MSB  -: 4];
   assign rd  = if_instr[RD_MSB  -: 4];
   assign rs1 = if_instr[RS1_MSB -: 4];
   assign rs2 = if_instr[RS2_MSB -: 4];
   assign imm = {{(DATA_W-8){if_instr[IMM_MSB]}}, if_instr[IMM_MSB -: 8]};
   assign dec = decode_op(op);

   assign rf_raddr1 = rs1;
   assign rf_raddr2 = (op == OP_ST || op == OP_BEQ) ? rd : rs2;

   // ---- handshake ----
   assign space    = ~ex_valid_q | ex_ready;
   assign if_ready = flush | (space & ~hazard);
   assign issue    = if_valid & if_ready & ~flush;
   // Flushed entry that EX did not take this cycle will never write back.
   assign kill     = flush & ex_valid_q & ex_wen_q & ~ex_ready;

   hazard_scoreboard u_sb (
      .clock       (clock),
      .reset_n     (reset_n),
      .src1_addr_i (rs1),
      .src1_use_i  (dec.uses_rs1),
      .src2_addr_i (rf_raddr2),
      .src2_use_i  (dec.uses_src2),
      .dst_addr_i  (rd),
      .dst_use_i   (dec.writes_rd),
      .set_i       (issue & dec.writes_rd),
      .set_addr_i  (rd),
      .clr_i       (wb_we),
      .clr_addr_i  (wb_addr),
      .kill_i      (kill),
      .kill_addr_i (ex_rd_q),
      .hazard_o    (hazard)
   );

   // ---- ID/EX register ----
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_op_d    = ex_op_q;
      ex_rd_d    = ex_rd_q;
      ex_a_d     = ex_a_q;
      ex_b_d     = ex_b_q;
      ex_imm_d   = ex_imm_q;
      ex_pc_d    = ex_pc_q;
      ex_wen_d   = ex_wen_q;
      if (issue) begin
         ex_valid_d = 1'b1;
         ex_op_d    = op;
         ex_rd_d    = rd;
         ex_a_d     = rf_rdata1;
         ex_b_d     = rf_rdata2;
         ex_imm_d   = imm;
         ex_pc_d    = if_pc;
         ex_wen_d   = dec.writes_rd;
      end else if (flush || ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (if_valid && hazard && !flush && stall_q != '1)
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= '0;
         ex_rd_q    <= '0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_imm_q   <= '0;
         ex_pc_q    <= '0;
         ex_wen_q   <= 1'b0;
         stall_q    <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_op_q    <= ex_op_d;
         ex_rd_q    <= ex_rd_d;
         ex_a_q     <= ex_a_d;
         ex_b_q     <= ex_b_d;
         ex_imm_q   <= ex_imm_d;
         ex_pc_q    <= ex_pc_d;
         ex_wen_q   <= ex_wen_d;
         stall_q    <= stall_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_op     = ex_op_q;
   assign ex_rd     = ex_rd_q;
   assign ex_a      = ex_a_q;
   assign ex_b      = ex_b_q;
   assign ex_imm    = ex_imm_q;
   assign ex_pc     = ex_pc_q;
   assign ex_wen    = ex_wen_q;
   assign stall_cnt = stall_q;

endmodule
